// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START, STOP, byte WRITE with ACK check and byte READ with ACK/NACK.
// Every phase is four quarters of SCL; open-drain lines are driven through pull-low enables.
module i2c_master_byte #(
    parameter int QTR        = 25,
    parameter int QTR_W      = 8,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       rx_nack,
    output logic [7:0] rx_data,
    output logic       ack_err,
    output logic       done,
    output logic       busy,
    output logic       scl_oe,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam logic [QTR_W-1:0] QTR_LAST = QTR_W'(QTR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_STOP,
        S_BIT
    } state_t;

    state_t            state_q, state_d;
    logic [QTR_W-1:0]  qcnt_q, qcnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [3:0]        bit_q, bit_d;
    logic              wr_q, wr_d;
    logic              nack_q, nack_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              ack_bit_q, ack_bit_d;
    logic              scl_oe_q, scl_oe_d;
    logic              sda_oe_q, sda_oe_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              ack_err_q, ack_err_d;
    logic              done_q, done_d;

    logic              active;
    logic              stretch_hold;
    logic              qtick;

    assign active    = (state_q != S_IDLE);
    assign busy      = active;
    assign cmd_ready = !active;
    assign rx_data   = rx_data_q;
    assign ack_err   = ack_err_q;
    assign done      = done_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

    // A slave holding SCL low during the released quarter freezes the timer, so q1
    // always lasts a full quarter after SCL is actually seen high.
    always_comb begin
        stretch_hold = STRETCH_EN && active && (qtr_q == 2'd1) && !scl_in;
        qtick        = active && !stretch_hold && (qcnt_q == QTR_LAST);
    end

    always_comb begin
        qcnt_d = qcnt_q + QTR_W'(1);
        if (!active || stretch_hold || qtick) begin
            qcnt_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        wr_d      = wr_q;
        nack_d    = nack_q;
        shreg_d   = shreg_q;
        ack_bit_d = ack_bit_q;
        scl_oe_d  = scl_oe_q;
        sda_oe_d  = sda_oe_q;
        rx_data_d = rx_data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    qtr_d   = 2'd0;
                    bit_d   = 4'd0;
                    nack_d  = rx_nack;
                    shreg_d = tx_data;
                    wr_d    = (cmd == CMD_WRITE);
                    // Outputs for q0 of the new command take effect on the acceptance edge.
                    case (cmd)
                        CMD_START: begin
                            state_d  = S_START;
                            sda_oe_d = 1'b0;
                        end
                        CMD_STOP: begin
                            state_d  = S_STOP;
                            sda_oe_d = 1'b1;
                            scl_oe_d = 1'b1;
                        end
                        CMD_WRITE: begin
                            state_d  = S_BIT;
                            scl_oe_d = 1'b1;
                            sda_oe_d = !tx_data[7];
                        end
                        default: begin
                            state_d  = S_BIT;
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b0;
                        end
                    endcase
                end
            end

            S_START: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0: scl_oe_d = 1'b0;
                        2'd1: sda_oe_d = 1'b1;
                        2'd2: scl_oe_d = 1'b1;
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            S_STOP: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0: scl_oe_d = 1'b0;
                        2'd1: sda_oe_d = 1'b0;
                        2'd2: ;
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            S_BIT: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0: scl_oe_d = 1'b0;
                        2'd1: begin
                            if (bit_q == 4'd8) begin
                                ack_bit_d = sda_in;
                            end else if (!wr_q) begin
                                shreg_d = {shreg_q[6:0], sda_in};
                            end
                        end
                        2'd2: scl_oe_d = 1'b1;
                        default: begin
                            if (bit_q == 4'd8) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                if (wr_q) begin
                                    ack_err_d = ack_bit_q;
                                end else begin
                                    rx_data_d = shreg_q;
                                end
                            end else begin
                                bit_d = bit_q + 4'd1;
                                if (wr_q) begin
                                    shreg_d  = {shreg_q[6:0], 1'b0};
                                    sda_oe_d = (bit_q == 4'd7) ? 1'b0 : !shreg_q[6];
                                end else begin
                                    sda_oe_d = (bit_q == 4'd7) ? !nack_q : 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 4'd0;
            wr_q      <= 1'b0;
            nack_q    <= 1'b0;
            shreg_q   <= 8'd0;
            ack_bit_q <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            rx_data_q <= 8'd0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            wr_q      <= wr_d;
            nack_q    <= nack_d;
            shreg_q   <= shreg_d;
            ack_bit_q <= ack_bit_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
            rx_data_q <= rx_data_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

endmodule
